// File: rtl/i2sin.sv
// I2S receive deserializer: recovers left/right words from ws/sd.
// Left-justified, MSB first, ws=0 left, ws=1 right, idle allowed.
module i2sin #(
  parameter int BITS_PRECISION = 24
) (
  input  logic                      sck,
  input  logic                      rst,
  input  logic                      ws,
  input  logic                      sd,
  output logic [BITS_PRECISION-1:0] l_data,
  output logic [BITS_PRECISION-1:0] r_data,
  output logic                      data_valid,
  output logic                      frame_err
);

  localparam int B  = BITS_PRECISION;
  localparam int CW = $clog2(B + 1);

  typedef enum logic [1:0] {
    SEEK,
    RIGHT,
    SKIP
  } state_t;

  state_t         state;
  logic [B-1:0]   sr_l;
  logic [B-1:0]   sr_r;
  logic [B-1:0]   left_hold;
  logic [CW-1:0]  low_cnt;
  logic [CW-1:0]  bit_cnt;
  logic           ws_d;
  logic           rise;
  logic           low_full;
  logic           last_bit;

  assign rise     = ws && !ws_d;
  assign low_full = (low_cnt == CW'(B));
  assign last_bit = (bit_cnt == CW'(B - 1));

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state      <= SEEK;
      sr_l       <= '0;
      sr_r       <= '0;
      left_hold  <= '0;
      low_cnt    <= '0;
      bit_cnt    <= '0;
      ws_d       <= 1'b1;
      l_data     <= '0;
      r_data     <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      ws_d       <= ws;

      if (!ws) begin
        sr_l <= {sr_l[B-2:0], sd};
        if (!low_full)
          low_cnt <= low_cnt + CW'(1);
      end else begin
        low_cnt <= '0;
      end

      unique case (state)
        SEEK: begin
          if (rise) begin
            if (low_full) begin
              left_hold <= sr_l;
              sr_r      <= {sr_r[B-2:0], sd};
              bit_cnt   <= CW'(1);
              state     <= RIGHT;
            end else begin
              frame_err <= 1'b1;
              state     <= SKIP;
            end
          end else if (ws && data_valid) begin
            // ws still high right after a full right word: overlong
            frame_err <= 1'b1;
            state     <= SKIP;
          end
        end
        RIGHT: begin
          if (ws) begin
            sr_r <= {sr_r[B-2:0], sd};
            if (last_bit) begin
              l_data     <= left_hold;
              r_data     <= {sr_r[B-2:0], sd};
              data_valid <= 1'b1;
              bit_cnt    <= '0;
              state      <= SEEK;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else begin
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            state     <= SEEK;
          end
        end
        SKIP: begin
          if (!ws)
            state <= SEEK;
        end
        default: state <= SEEK;
      endcase
    end
  end

endmodule

// File: tb/tb_i2sin.sv
// Directed bench for i2sin: serial frames driven on negedge,
// outputs sampled 1ns after posedge.
module tb_i2sin;

  localparam int B = 24;

  logic         sck = 1'b0;
  logic         rst = 1'b1;
  logic         ws = 1'b1;
  logic         sd = 1'b0;
  logic [B-1:0] l_data;
  logic [B-1:0] r_data;
  logic         data_valid;
  logic         frame_err;

  i2sin #(.BITS_PRECISION(B)) dut (
    .sck        (sck),
    .rst        (rst),
    .ws         (ws),
    .sd         (sd),
    .l_data     (l_data),
    .r_data     (r_data),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  always #5 sck = ~sck;

  int n_chk   = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int dv_seen = 0;
  int fe_seen = 0;
  int dv_cyc  = -1;
  int fe_cyc  = -1;
  int both_hi = 0;

  task automatic send_bit(input logic w, input logic d);
    @(negedge sck);
    ws = w;
    sd = d;
    @(posedge sck);
    cyc++;
    #1;
    if (data_valid === 1'b1) begin
      dv_seen++;
      dv_cyc = cyc;
    end
    if (frame_err === 1'b1) begin
      fe_seen++;
      fe_cyc = cyc;
    end
    if (data_valid === 1'b1 && frame_err === 1'b1)
      both_hi++;
  endtask

  task automatic send_word(input logic w, input logic [B-1:0] v,
                           input int n);
    for (int i = 0; i < n; i++)
      send_bit(w, v[B-1-i]);
  endtask

  task automatic send_frame(input logic [B-1:0] l, input logic [B-1:0] r,
                            input int idle, output int rise);
    for (int i = 0; i < idle; i++)
      send_bit(1'b0, 1'b0);
    send_word(1'b0, l, B);
    rise = cyc + 1;
    send_word(1'b1, r, B);
  endtask

  task automatic test_reset();
    int d0, f0;
    rst = 1'b1;
    ws  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sck);
      sd = ~sd;
    end
    #1;
    n_chk++;
    if (l_data !== '0) $display("FAIL rst_l: got %h want 0", l_data);
    else n_pass++;
    n_chk++;
    if (r_data !== '0) $display("FAIL rst_r: got %h want 0", r_data);
    else n_pass++;
    n_chk++;
    if (data_valid !== 1'b0) $display("FAIL rst_dv: got %b want 0", data_valid);
    else n_pass++;
    n_chk++;
    if (frame_err !== 1'b0) $display("FAIL rst_fe: got %b want 0", frame_err);
    else n_pass++;
    @(negedge sck);
    rst = 1'b0;
    d0 = dv_seen;
    f0 = fe_seen;
    for (int i = 0; i < 10; i++)
      send_bit(1'b1, i[0]);
    n_chk++;
    if (dv_seen != d0) $display("FAIL rst_hold_dv: got %0d want 0", dv_seen - d0);
    else n_pass++;
    n_chk++;
    if (fe_seen != f0) $display("FAIL rst_hold_fe: got %0d want 0", fe_seen - f0);
    else n_pass++;
  endtask

  task automatic test_single();
    int d0, f0, rise;
    d0 = dv_seen;
    f0 = fe_seen;
    send_frame(24'hA5A5A5, 24'h5A5A5A, 5, rise);
    n_chk++;
    if (dv_seen - d0 != 1) $display("FAIL single_dv: got %0d want 1", dv_seen - d0);
    else n_pass++;
    n_chk++;
    if (fe_seen != f0) $display("FAIL single_fe: got %0d want 0", fe_seen - f0);
    else n_pass++;
    n_chk++;
    if (l_data !== 24'hA5A5A5) $display("FAIL single_l: got %h want a5a5a5", l_data);
    else n_pass++;
    n_chk++;
    if (r_data !== 24'h5A5A5A) $display("FAIL single_r: got %h want 5a5a5a", r_data);
    else n_pass++;
    n_chk++;
    if (dv_cyc != rise + B - 1)
      $display("FAIL single_lat: got %0d want %0d", dv_cyc - rise, B - 1);
    else n_pass++;
    send_bit(1'b0, 1'b0);
    n_chk++;
    if (dv_seen - d0 != 1) $display("FAIL single_pulse: got %0d want 1", dv_seen - d0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [B-1:0] lv [3];
    logic [B-1:0] rv [3];
    int c [3];
    int d0, f0, rise;
    lv[0] = 24'h000001; rv[0] = 24'h800000;
    lv[1] = 24'hFFFFFF; rv[1] = 24'h000000;
    lv[2] = 24'h123456; rv[2] = 24'h654321;
    d0 = dv_seen;
    f0 = fe_seen;
    for (int k = 0; k < 3; k++) begin
      send_frame(lv[k], rv[k], 0, rise);
      c[k] = dv_cyc;
      n_chk++;
      if (l_data !== lv[k]) $display("FAIL b2b_l%0d: got %h want %h", k, l_data, lv[k]);
      else n_pass++;
      n_chk++;
      if (r_data !== rv[k]) $display("FAIL b2b_r%0d: got %h want %h", k, r_data, rv[k]);
      else n_pass++;
      n_chk++;
      if (dv_seen - d0 != k + 1) $display("FAIL b2b_dv%0d: got %0d want %0d", k, dv_seen - d0, k + 1);
      else n_pass++;
    end
    for (int k = 1; k < 3; k++) begin
      n_chk++;
      if (c[k] - c[k-1] != 2 * B)
        $display("FAIL b2b_gap%0d: got %0d want %0d", k, c[k] - c[k-1], 2 * B);
      else n_pass++;
    end
    n_chk++;
    if (fe_seen != f0) $display("FAIL b2b_fe: got %0d want 0", fe_seen - f0);
    else n_pass++;
  endtask

  task automatic test_short_right();
    int d0, f0, rise;
    d0 = dv_seen;
    f0 = fe_seen;
    send_word(1'b0, 24'hDEADBE, B);
    send_word(1'b1, 24'hCAFE12, 10);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    n_chk++;
    if (fe_seen - f0 != 1) $display("FAIL sr_fe: got %0d want 1", fe_seen - f0);
    else n_pass++;
    n_chk++;
    if (fe_cyc != cyc - 1) $display("FAIL sr_fe_at: got %0d want %0d", fe_cyc, cyc - 1);
    else n_pass++;
    n_chk++;
    if (dv_seen != d0) $display("FAIL sr_dv: got %0d want 0", dv_seen - d0);
    else n_pass++;
    n_chk++;
    if (l_data !== 24'h123456) $display("FAIL sr_hold_l: got %h want 123456", l_data);
    else n_pass++;
    n_chk++;
    if (r_data !== 24'h654321) $display("FAIL sr_hold_r: got %h want 654321", r_data);
    else n_pass++;
    send_frame(24'h0F0F0F, 24'hF0F0F0, 0, rise);
    n_chk++;
    if (l_data !== 24'h0F0F0F) $display("FAIL sr_next_l: got %h want 0f0f0f", l_data);
    else n_pass++;
    n_chk++;
    if (r_data !== 24'hF0F0F0) $display("FAIL sr_next_r: got %h want f0f0f0", r_data);
    else n_pass++;
    n_chk++;
    if (dv_seen - d0 != 1 || fe_seen - f0 != 1)
      $display("FAIL sr_next_cnt: got dv %0d fe %0d want 1 1", dv_seen - d0, fe_seen - f0);
    else n_pass++;
  endtask

  task automatic test_short_left();
    int d0, f0, rise;
    send_word(1'b0, 24'h111111, 12);
    @(negedge sck);
    rst = 1'b1;
    #1;
    n_chk++;
    if (l_data !== '0 || r_data !== '0)
      $display("FAIL mid_rst: got %h %h want 0 0", l_data, r_data);
    else n_pass++;
    ws = 1'b1;
    sd = 1'b0;
    @(negedge sck);
    rst = 1'b0;
    d0 = dv_seen;
    f0 = fe_seen;
    for (int i = 0; i < 5; i++)
      send_bit(1'b0, 1'b1);
    rise = cyc + 1;
    send_word(1'b1, 24'hFFFFFF, B);
    n_chk++;
    if (fe_seen - f0 != 1) $display("FAIL sl_fe: got %0d want 1", fe_seen - f0);
    else n_pass++;
    n_chk++;
    if (fe_cyc != rise) $display("FAIL sl_fe_at: got %0d want %0d", fe_cyc, rise);
    else n_pass++;
    n_chk++;
    if (dv_seen != d0 || l_data !== '0)
      $display("FAIL sl_dv: got dv %0d l %h want 0 0", dv_seen - d0, l_data);
    else n_pass++;
    send_frame(24'hABCDEF, 24'h13579B, 0, rise);
    n_chk++;
    if (l_data !== 24'hABCDEF) $display("FAIL sl_next_l: got %h want abcdef", l_data);
    else n_pass++;
    n_chk++;
    if (r_data !== 24'h13579B) $display("FAIL sl_next_r: got %h want 13579b", r_data);
    else n_pass++;
    n_chk++;
    if (dv_seen - d0 != 1 || fe_seen - f0 != 1)
      $display("FAIL sl_next_cnt: got dv %0d fe %0d want 1 1", dv_seen - d0, fe_seen - f0);
    else n_pass++;
  endtask

  task automatic test_long_right();
    int d0, f0, rise;
    d0 = dv_seen;
    f0 = fe_seen;
    send_word(1'b0, 24'h2468AC, B);
    rise = cyc + 1;
    send_word(1'b1, 24'h9BDF13, B);
    for (int i = 0; i < 6; i++)
      send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    n_chk++;
    if (dv_seen - d0 != 1) $display("FAIL lr_dv: got %0d want 1", dv_seen - d0);
    else n_pass++;
    n_chk++;
    if (dv_cyc != rise + B - 1) $display("FAIL lr_dv_at: got %0d want %0d", dv_cyc, rise + B - 1);
    else n_pass++;
    n_chk++;
    if (fe_seen - f0 != 1) $display("FAIL lr_fe: got %0d want 1", fe_seen - f0);
    else n_pass++;
    n_chk++;
    if (fe_cyc != rise + B) $display("FAIL lr_fe_at: got %0d want %0d", fe_cyc, rise + B);
    else n_pass++;
    n_chk++;
    if (l_data !== 24'h2468AC || r_data !== 24'h9BDF13)
      $display("FAIL lr_data: got %h %h want 2468ac 9bdf13", l_data, r_data);
    else n_pass++;
    send_frame(24'h000F00, 24'h00F000, 2, rise);
    n_chk++;
    if (l_data !== 24'h000F00 || r_data !== 24'h00F000)
      $display("FAIL lr_next: got %h %h want 000f00 00f000", l_data, r_data);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_short_right();
    test_short_left();
    test_long_right();
    n_chk++;
    if (both_hi != 0) $display("FAIL dv_fe_overlap: got %0d want 0", both_hi);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
